// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types, constants and read-extension helper for the mem access unit
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    DT_BYTE  = 3'd0,
    DT_HALF  = 3'd1,
    DT_WORD  = 3'd2,
    DT_UBYTE = 3'd3,
    DT_UHALF = 3'd4
  } mem_dt_e;

  typedef enum logic [3:0] {
    ERR_OK    = 4'd0,
    ERR_ALIGN = 4'd1,
    ERR_BUS   = 4'd2
  } errno_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } mem_acc_state_e;

  localparam int MEM_MAX_BEATS = 4;

  // Applies the sign/zero extension that mem itself would do for an aligned access.
  function automatic logic [31:0] extend_rd(input mem_dt_e dt, input logic [31:0] v);
    case (dt)
      DT_BYTE:  extend_rd = {{24{v[7]}}, v[7:0]};
      DT_UBYTE: extend_rd = {24'b0, v[7:0]};
      DT_HALF:  extend_rd = {{16{v[15]}}, v[15:0]};
      DT_UHALF: extend_rd = {16'b0, v[15:0]};
      default:  extend_rd = v;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_split_dec.sv
// rtl/mem_access_unit_split_dec.sv - decides how many byte beats a request needs and whether it is misaligned
module mem_split_dec
  import mem_access_unit_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  mem_dt_e    dt,
  output logic [2:0] nbeats,
  output logic       misaligned
);

  always_comb begin
    nbeats     = 3'd1;
    misaligned = 1'b0;
    case (dt)
      DT_HALF, DT_UHALF: begin
        if (addr_lo[0]) begin
          nbeats     = 3'd2;
          misaligned = 1'b1;
        end
      end
      DT_WORD: begin
        if (addr_lo != 2'b00) begin
          nbeats     = 3'(MEM_MAX_BEATS);
          misaligned = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for the strict-aligned mem port, splitting misaligned accesses into byte beats
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  input  logic        req_we,
  input  mem_dt_e     req_dt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output errno_e      rsp_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wd,
  output logic        m_we,
  output mem_dt_e     m_dt,
  input  logic [31:0] m_rd,
  input  errno_e      m_err
);

  mem_acc_state_e state, state_nx;
  logic [31:0] addr_q, wd_q, acc_q, acc_nx, rd_q;
  logic        we_q;
  mem_dt_e     dt_q;
  logic [2:0]  nbeats_q, beat_q, dec_nbeats;
  errno_e      err_q;
  logic        dec_mis, reject, split, last_beat;

  mem_split_dec u_split_dec (
    .addr_lo    (req_addr[1:0]),
    .dt         (req_dt),
    .nbeats     (dec_nbeats),
    .misaligned (dec_mis)
  );

  assign reject    = dec_mis && !ALLOW_MISALIGNED;
  assign split     = (nbeats_q != 3'd1);
  assign last_beat = (beat_q == nbeats_q - 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = reject ? RESP : XFER;
      XFER:    if (last_beat) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Split loads gather one byte per beat; single-beat loads take mem's already-extended word.
  always_comb begin
    acc_nx = acc_q;
    if (!split) acc_nx = m_rd;
    else        acc_nx[{beat_q[1:0], 3'b000} +: 8] = m_rd[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= 32'b0;
      wd_q     <= 32'b0;
      we_q     <= 1'b0;
      dt_q     <= DT_BYTE;
      nbeats_q <= 3'd1;
      beat_q   <= 3'd0;
      acc_q    <= 32'b0;
      rd_q     <= 32'b0;
      err_q    <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wd_q     <= req_wd;
            we_q     <= req_we;
            dt_q     <= req_dt;
            nbeats_q <= dec_nbeats;
            beat_q   <= 3'd0;
            acc_q    <= 32'b0;
            rd_q     <= 32'b0;
            err_q    <= reject ? ERR_ALIGN : ERR_OK;
          end
        end
        XFER: begin
          if (m_err != ERR_OK) err_q <= m_err;
          if (!we_q) acc_q <= acc_nx;
          if (last_beat) begin
            if (!we_q) rd_q <= split ? extend_rd(dt_q, acc_nx) : acc_nx;
          end else begin
            beat_q <= beat_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // m_we is gated with rst_n so a reset edge never doubles as a write edge.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    m_we      = (state == XFER) && we_q && rst_n;
    m_addr    = addr_q + {29'b0, beat_q};
    if (split) begin
      m_dt = DT_UBYTE;
      m_wd = {24'b0, wd_q[{beat_q[1:0], 3'b000} +: 8]};
    end else begin
      m_dt = dt_q;
      m_wd = wd_q;
    end
  end

  assign rsp_rd  = rd_q;
  assign rsp_err = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench pairing the unit with a 64-byte strict-aligned mem model
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] rd;
    errno_e      err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, clear_mem;
  logic req_valid, req_ready, req_we, rsp_valid, rsp_ready, m_we;
  logic [31:0] req_addr, req_wd, rsp_rd, m_addr, m_wd, m_rd;
  mem_dt_e req_dt, m_dt;
  errno_e  rsp_err, m_err;

  logic req_valid1, req_ready1, rsp_valid1, rsp_ready1, m_we1, m_we1_seen;
  logic [31:0] rsp_rd1, m_addr1, m_wd1, m_rd1;
  mem_dt_e m_dt1;
  errno_e  rsp_err1, m_err1;

  logic [7:0] mem [0:63];
  int wa;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, first_cyc = 0;
  logic prev_valid = 1'b0;
  logic [31:0] first_rd;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wd(req_wd), .req_we(req_we), .req_dt(req_dt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_dt(m_dt), .m_rd(m_rd), .m_err(m_err)
  );

  mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_addr(req_addr), .req_wd(req_wd), .req_we(req_we), .req_dt(req_dt),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rd(rsp_rd1), .rsp_err(rsp_err1),
    .m_addr(m_addr1), .m_wd(m_wd1), .m_we(m_we1), .m_dt(m_dt1), .m_rd(m_rd1), .m_err(m_err1)
  );

  // Strict-aligned mem: asynchronous read, write on posedge, addresses >= 64 report ERR_BUS.
  always_comb begin
    m_rd  = 32'b0;
    m_err = ERR_OK;
    wa    = int'(m_addr[5:0]);
    if (m_addr >= 32'd64) m_err = ERR_BUS;
    else begin
      case (m_dt)
        DT_BYTE:  m_rd = {{24{mem[wa][7]}}, mem[wa]};
        DT_UBYTE: m_rd = {24'b0, mem[wa]};
        DT_HALF, DT_UHALF: begin
          if (m_addr[0]) m_err = ERR_ALIGN;
          else if (m_dt == DT_HALF) m_rd = {{16{mem[wa+1][7]}}, mem[wa+1], mem[wa]};
          else m_rd = {16'b0, mem[wa+1], mem[wa]};
        end
        DT_WORD: begin
          if (m_addr[1:0] != 2'b00) m_err = ERR_ALIGN;
          else m_rd = {mem[wa+3], mem[wa+2], mem[wa+1], mem[wa]};
        end
        default: m_err = ERR_BUS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (m_we && m_err == ERR_OK) begin
      mem[wa] <= m_wd[7:0];
      if (m_dt == DT_HALF || m_dt == DT_UHALF || m_dt == DT_WORD) mem[wa+1] <= m_wd[15:8];
      if (m_dt == DT_WORD) begin
        mem[wa+2] <= m_wd[23:16];
        mem[wa+3] <= m_wd[31:24];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each response handshake; checks hold-stability while stalled.
  always @(negedge clk) begin
    if (req_valid && req_ready) acc_cyc = cyc;
    if (rst_n && rsp_valid) begin
      if (!prev_valid) begin
        first_cyc = cyc;
        first_rd  = rsp_rd;
      end else begin
        chk("held_rd", rsp_rd, first_rd);
        chk("held_req_ready", 32'(req_ready), 32'd0);
      end
      if (rsp_ready) begin
        if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk({e.name, "_rd"}, rsp_rd, e.rd);
          chk({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
          chk({e.name, "_lat"}, 32'(first_cyc - acc_cyc), 32'(e.lat));
        end
      end
    end
    prev_valid = rst_n && rsp_valid && !rsp_ready;
  end

  always @(negedge clk) if (m_we1) m_we1_seen = 1'b1;

  task automatic issue(input string name, input logic [31:0] addr, input logic [31:0] wd,
                       input logic we, input mem_dt_e dt, input logic [31:0] exp_rd,
                       input errno_e exp_err, input int exp_lat);
    exp_t x;
    int n;
    x.name = name; x.rd = exp_rd; x.err = exp_err; x.lat = exp_lat;
    sb.push_back(x);
    @(posedge clk); #1;
    req_addr = addr; req_wd = wd; req_we = we; req_dt = dt; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk({name, "_accept_timeout"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int n, c0;
    rst_n = 1'b0; clear_mem = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0;
    rsp_ready = 1'b1; rsp_ready1 = 1'b1; m_rd1 = 32'b0; m_err1 = ERR_OK; m_we1_seen = 1'b0;
    req_addr = 32'b0; req_wd = 32'b0; req_we = 1'b0; req_dt = DT_BYTE;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; clear_mem = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rd", rsp_rd, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);

    issue("st_w_al", 32'h10, 32'hDEADBEEF, 1'b1, DT_WORD, 32'h0, ERR_OK, 2);
    issue("ld_w_al", 32'h10, 32'h0, 1'b0, DT_WORD, 32'hDEADBEEF, ERR_OK, 2);
    drain();

    issue("st_w_mis", 32'h21, 32'h11223344, 1'b1, DT_WORD, 32'h0, ERR_OK, 5);
    drain();
    chk("mem_21", 32'(mem[8'h21]), 32'h44);
    chk("mem_22", 32'(mem[8'h22]), 32'h33);
    chk("mem_23", 32'(mem[8'h23]), 32'h22);
    chk("mem_24", 32'(mem[8'h24]), 32'h11);
    issue("ld_w_mis", 32'h21, 32'h0, 1'b0, DT_WORD, 32'h11223344, ERR_OK, 5);

    issue("st_b_33", 32'h33, 32'h80, 1'b1, DT_BYTE, 32'h0, ERR_OK, 2);
    issue("st_b_34", 32'h34, 32'hFF, 1'b1, DT_BYTE, 32'h0, ERR_OK, 2);
    issue("ld_h_mis", 32'h33, 32'h0, 1'b0, DT_HALF, 32'hFFFFFF80, ERR_OK, 3);
    issue("ld_uh_mis", 32'h33, 32'h0, 1'b0, DT_UHALF, 32'h0000FF80, ERR_OK, 3);

    issue("st_b_00", 32'h0, 32'h9A, 1'b1, DT_BYTE, 32'h0, ERR_OK, 2);
    issue("ld_h_wrap", 32'hFFFFFFFF, 32'h0, 1'b0, DT_HALF, 32'hFFFF9A00, ERR_BUS, 3);
    issue("st_b_3f", 32'h3F, 32'h5C, 1'b1, DT_BYTE, 32'h0, ERR_OK, 2);
    issue("ld_w_edge", 32'h3E, 32'h0, 1'b0, DT_WORD, 32'h00005C00, ERR_BUS, 5);
    drain();

    rsp_ready = 1'b0;
    issue("ld_w_hold", 32'h10, 32'h0, 1'b0, DT_WORD, 32'hDEADBEEF, ERR_OK, 2);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("hold_valid", 32'(rsp_valid), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain();
    issue("ld_after_hold", 32'h21, 32'h0, 1'b0, DT_WORD, 32'h11223344, ERR_OK, 5);
    drain();

    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      req_addr = 32'h2; req_wd = 32'h12345678; req_we = i[0]; req_dt = DT_WORD; req_valid1 = 1'b1;
      @(negedge clk);
      chk("strict_ready", 32'(req_ready1), 32'd1);
      c0 = cyc;
      @(posedge clk); #1 req_valid1 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid1 && n < 20) begin @(negedge clk); n++; end
      chk("strict_lat", 32'(cyc - c0), 32'd1);
      chk("strict_rd", rsp_rd1, 32'd0);
      chk("strict_err", 32'(rsp_err1), 32'(ERR_ALIGN));
    end
    chk("strict_no_we", 32'(m_we1_seen), 32'd0);

    @(posedge clk); #1;
    req_addr = 32'h29; req_wd = 32'hAABBCCDD; req_we = 1'b1; req_dt = DT_WORD; req_valid = 1'b1;
    @(negedge clk);
    chk("rstx_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstx_we_gated", 32'(m_we), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstx_req_ready", 32'(req_ready), 32'd1);
    chk("rstx_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstx_rsp_rd", rsp_rd, 32'd0);
    chk("rstx_rsp_err", 32'(rsp_err), 32'd0);
    chk("rstx_m_we", 32'(m_we), 32'd0);
    chk("rstx_mem_29", 32'(mem[8'h29]), 32'hDD);
    chk("rstx_mem_2a", 32'(mem[8'h2A]), 32'hCC);
    chk("rstx_mem_2b", 32'(mem[8'h2B]), 32'h00);
    chk("rstx_mem_2c", 32'(mem[8'h2C]), 32'h00);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
